random_tile_picker: RTL and testbench

Consumer side of the 4-bit random nibble stream produced by the game's LFSR random number generator. On request from the spawn/drop logic, it draws nibbles from the stream and uses rejection sampling to pick an in-range tile coordinate (x, y). It asks the map logic whether the candidate tile is blocked and retries until it finds a free tile or runs out of attempts. The result is returned as a one-cycle valid pulse with held coordinates.

---
 rtl/random_tile_picker.sv | 168 ++++++++++++++++
 tb/tb_random_tile_picker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_tile_picker.sv
// random_tile_picker: draws nibbles from the LFSR stream and uses rejection
// sampling to pick an in-range tile. Each candidate is checked against the map,
// and the search retries until it finds a free tile or runs out of attempts.
// The result comes out as a one-cycle valid pulse, and the coordinates stay
// held until the next result.
module random_tile_picker #(
  parameter int X_TILES     = 10,
  parameter int Y_TILES     = 7,
  parameter int MAX_TRIES   = 8,
  parameter int MAX_REJECTS = 32,
  parameter int FALLBACK_X  = 0,
  parameter int FALLBACK_Y  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rn,
  input  logic       req,
  input  logic       cand_blocked,
  output logic       busy,
  output logic       cand_valid,
  output logic [3:0] cand_x,
  output logic [3:0] cand_y,
  output logic       valid,
  output logic [3:0] tile_x,
  output logic [3:0] tile_y,
  output logic       fallback
);

  // 5-bit limits so that a tile count of 16 accepts every nibble
  localparam logic [4:0] X_LIM   = 5'(X_TILES);
  localparam logic [4:0] Y_LIM   = 5'(Y_TILES);
  localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);
  localparam logic [7:0] REJ_LIM = 8'(MAX_REJECTS);
  localparam logic [3:0] FB_X    = 4'(FALLBACK_X);
  localparam logic [3:0] FB_Y    = 4'(FALLBACK_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW_X,
    S_DRAW_Y,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       busy_q;
  logic       cand_valid_q;
  logic       valid_q;
  logic       fallback_q;
  logic [3:0] cand_x_q;
  logic [3:0] cand_y_q;
  logic [3:0] tile_x_q;
  logic [3:0] tile_y_q;
  logic [7:0] tries_q;
  logic [7:0] rejects_q;

  logic       x_ok;
  logic       y_ok;
  logic [7:0] tries_d;
  logic [7:0] rejects_d;

  // Range test on the incoming nibble and the incremented attempt counters
  always_comb begin
    x_ok      = ({1'b0, rn} < X_LIM);
    y_ok      = ({1'b0, rn} < Y_LIM);
    tries_d   = tries_q + 8'd1;
    rejects_d = rejects_q + 8'd1;
  end

  // Pick FSM; status flags are registered alongside the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      fallback_q   <= 1'b0;
      cand_x_q     <= 4'd0;
      cand_y_q     <= 4'd0;
      tile_x_q     <= 4'd0;
      tile_y_q     <= 4'd0;
      tries_q      <= 8'd0;
      rejects_q    <= 8'd0;
    end else begin
      cand_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            tries_q   <= 8'd0;
            rejects_q <= 8'd0;
            busy_q    <= 1'b1;
            state_q   <= S_DRAW_X;
          end
        end
        S_DRAW_X: begin
          if (x_ok) begin
            cand_x_q <= rn;
            state_q  <= S_DRAW_Y;
          end else begin
            rejects_q <= rejects_d;
            if (rejects_d == REJ_LIM) begin
              tile_x_q   <= FB_X;
              tile_y_q   <= FB_Y;
              fallback_q <= 1'b1;
              valid_q    <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_DRAW_Y: begin
          if (y_ok) begin
            cand_y_q     <= rn;
            cand_valid_q <= 1'b1;
            state_q      <= S_CHECK;
          end else begin
            rejects_q <= rejects_d;
            if (rejects_d == REJ_LIM) begin
              tile_x_q   <= FB_X;
              tile_y_q   <= FB_Y;
              fallback_q <= 1'b1;
              valid_q    <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_CHECK: begin
          if (!cand_blocked) begin
            tile_x_q   <= cand_x_q;
            tile_y_q   <= cand_y_q;
            fallback_q <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tries_q <= tries_d;
            if (tries_d == TRY_LIM) begin
              tile_x_q   <= FB_X;
              tile_y_q   <= FB_Y;
              fallback_q <= 1'b1;
              valid_q    <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              state_q <= S_DRAW_X;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign cand_valid = cand_valid_q;
  assign cand_x     = cand_x_q;
  assign cand_y     = cand_y_q;
  assign valid      = valid_q;
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign fallback   = fallback_q;

endmodule

// File: tb/tb_random_tile_picker.sv
// Directed bench for random_tile_picker with default parameters (10x7 tiles,
// 8 tries, 32 rejects, fallback tile (0,0)).
module tb_random_tile_picker;

  logic       clk;
  logic       rst;
  logic [3:0] rn;
  logic       req;
  logic       cand_blocked;
  logic       busy;
  logic       cand_valid;
  logic [3:0] cand_x;
  logic [3:0] cand_y;
  logic       valid;
  logic [3:0] tile_x;
  logic [3:0] tile_y;
  logic       fallback;

  // Map model: one blocked tile, or everything blocked
  logic       blk_en;
  logic       blk_all;
  logic [3:0] blk_x;
  logic [3:0] blk_y;

  logic [3:0] seq [0:63];
  int         seq_len;

  int n_chk;
  int n_err;

  random_tile_picker dut (
    .clk          (clk),
    .rst          (rst),
    .rn           (rn),
    .req          (req),
    .cand_blocked (cand_blocked),
    .busy         (busy),
    .cand_valid   (cand_valid),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .valid        (valid),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .fallback     (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cand_blocked = blk_all | (blk_en & (cand_x == blk_x) & (cand_y == blk_y));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_seq2(input logic [3:0] a, input logic [3:0] b);
    seq[0] = a; seq[1] = b; seq_len = 2;
  endtask

  // Issue one req from IDLE (called just after a rising edge) and follow the
  // pick until valid. lat counts cycles from the req cycle to the valid cycle.
  task automatic pick(input int budget, input bit glitch,
                      output int lat, output int cv_cnt, output int busy_cnt);
    int idx;
    lat = -1; cv_cnt = 0; busy_cnt = 0;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    rn  = seq[0];
    if (busy) busy_cnt++;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      idx = (k < seq_len) ? k : seq_len - 1;
      rn  = seq[idx];
      if (glitch) req = (k <= 3);
      if (busy) busy_cnt++;
      if (cand_valid) cv_cnt++;
      if (valid) begin
        lat = k + 1;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, cv, bc, nval, first, second, idle_cnt, stray;
    n_chk = 0; n_err = 0;
    rst = 1'b1; rn = 4'd0; req = 1'b0;
    blk_en = 1'b0; blk_all = 1'b0; blk_x = 4'd0; blk_y = 4'd0;
    seq_len = 1; seq[0] = 4'd0;

    // Power-on reset
    step(); step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_cand_valid", cand_valid, 0);
    check("rst_tile", {tile_x, tile_y}, 0);
    check("rst_cand", {cand_x, cand_y}, 0);
    check("rst_fallback", fallback, 0);
    step();

    // Direct hit (3,5)
    set_seq2(4'd3, 4'd5);
    pick(50, 1'b0, lat, cv, bc);
    check("hit_lat", lat, 4);
    check("hit_x", tile_x, 3);
    check("hit_y", tile_y, 5);
    check("hit_fb", fallback, 0);
    check("hit_busy_cycles", bc, 4);
    check("hit_cv", cv, 1);
    step();
    check("hit_busy_after", busy, 0);
    check("hit_valid_once", valid, 0);
    check("hit_hold", {tile_x, tile_y}, {4'd3, 4'd5});

    // Rejections: x 12,15,10 rejected, 4 accepted; y 9 rejected, 6 accepted
    seq[0] = 4'd12; seq[1] = 4'd15; seq[2] = 4'd10; seq[3] = 4'd4;
    seq[4] = 4'd9;  seq[5] = 4'd6;  seq_len = 6;
    pick(50, 1'b0, lat, cv, bc);
    check("rej_lat", lat, 8);
    check("rej_cand", {cand_x, cand_y}, {4'd4, 4'd6});
    check("rej_tile", {tile_x, tile_y}, {4'd4, 4'd6});
    check("rej_fb", fallback, 0);
    step();

    // Boundary: x=9 accepted, y=7 rejected, y=6 accepted
    seq[0] = 4'd9; seq[1] = 4'd7; seq[2] = 4'd6; seq_len = 3;
    pick(50, 1'b0, lat, cv, bc);
    check("bnd_lat", lat, 5);
    check("bnd_tile", {tile_x, tile_y}, {4'd9, 4'd6});
    step();

    // Blocked retry: (2,2) blocked, then (7,1) free
    blk_en = 1'b1; blk_x = 4'd2; blk_y = 4'd2;
    seq[0] = 4'd2; seq[1] = 4'd2; seq[2] = 4'd0; seq[3] = 4'd7; seq[4] = 4'd1;
    seq_len = 5;
    pick(50, 1'b0, lat, cv, bc);
    check("retry_lat", lat, 7);
    check("retry_tile", {tile_x, tile_y}, {4'd7, 4'd1});
    check("retry_fb", fallback, 0);
    check("retry_cv", cv, 2);
    blk_en = 1'b0;
    step();

    // Reject fallback: rn stuck at 15
    seq[0] = 4'd15; seq_len = 1;
    pick(100, 1'b0, lat, cv, bc);
    check("rejfb_lat", lat, 33);
    check("rejfb_tile", {tile_x, tile_y}, 0);
    check("rejfb_fb", fallback, 1);
    check("rejfb_cv", cv, 0);
    step();
    check("rejfb_hold", fallback, 1);

    // Clean pick clears fallback
    set_seq2(4'd3, 4'd5);
    pick(50, 1'b0, lat, cv, bc);
    check("clr_fb", fallback, 0);
    step();

    // Blocked fallback: every candidate blocked
    blk_all = 1'b1;
    seq[0] = 4'd1; seq_len = 1;
    pick(100, 1'b0, lat, cv, bc);
    check("blkfb_lat", lat, 25);
    check("blkfb_cv", cv, 8);
    check("blkfb_tile", {tile_x, tile_y}, 0);
    check("blkfb_fb", fallback, 1);
    blk_all = 1'b0;
    step();

    // req pulses while busy are ignored
    set_seq2(4'd4, 4'd2);
    pick(50, 1'b1, lat, cv, bc);
    check("glitch_lat", lat, 4);
    check("glitch_tile", {tile_x, tile_y}, {4'd4, 4'd2});
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy || valid) stray++;
    end
    check("glitch_no_restart", stray, 0);

    // req held high: back-to-back picks separated by one IDLE cycle
    rn = 4'd3; req = 1'b1;
    nval = 0; first = -1; second = -1; idle_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        nval++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (!busy) idle_cnt++;
    end
    req = 1'b0;
    check("held_pulses", nval, 3);
    check("held_gap", second - first, 5);
    check("held_idle", idle_cnt, 3);
    check("held_tile", {tile_x, tile_y}, {4'd3, 4'd3});
    for (int k = 0; k < 6; k++) step();

    // Reset in the middle of a pick (state DRAW_Y)
    set_seq2(4'd5, 4'd1);
    req = 1'b1;
    step();
    req = 1'b0; rn = 4'd5;
    step();
    rn = 4'd1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tile", {tile_x, tile_y}, 0);
    check("mid_rst_cand", {cand_x, cand_y}, 0);
    check("mid_rst_flags", {valid, cand_valid, fallback}, 0);
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (valid || busy) stray++;
    end
    check("mid_rst_no_valid", stray, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
